// File: rtl/sha256_msg_server_pkg.sv
// rtl/sha256_msg_server_pkg.sv - shared states, block constants and SHA-256 helper functions
package sha256_msg_server_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        PAD   = 2'd1,
        SERVE = 2'd2
    } state_t;

    localparam logic [7:0] PAD_BYTE     = 8'h80;
    localparam logic [6:0] LEN_BYTE_OFS = 7'd60;
    localparam logic [6:0] BLOCK_BYTES  = 7'd64;

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_msg_server.sv
// rtl/sha256_msg_server.sv - message block buffer with optional padding, serving words to the SHA-256 core
module sha256_msg_server
    import sha256_msg_server_pkg::*;
#(
    parameter int RDY_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        pad_en,
    input  logic [31:0] len_bits,
    input  logic [3:0]  addr,
    input  logic        rq,
    output logic        rdy,
    output logic [31:0] data,
    output logic        full,
    output logic        pad_ovf
);

    localparam logic [3:0] LP_WAIT = 4'(RDY_WAIT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [6:0]  r_cnt;
    logic [31:0] r_mem [16];
    logic        r_pad_first;
    logic        r_fit;
    logic [31:0] r_len;
    logic [3:0]  r_wait;
    logic [3:0]  r_addr;
    logic        r_rdy;
    logic [31:0] r_data;
    logic        r_pad_ovf;

    logic [6:0]  w_cnt_inc;
    logic        w_issue;
    logic        w_release;
    logic        w_ovf;
    logic        w_wr_en;
    logic [5:0]  w_wr_idx;
    logic [7:0]  w_wr_byte;

    assign w_cnt_inc = r_cnt + 7'd1;
    assign w_issue   = (r_state == SERVE) && rq && !r_rdy && (r_wait == LP_WAIT);
    // addr was latched when rdy was issued, so release follows the word actually served
    assign w_release = (r_state == SERVE) && r_rdy && (r_addr == 4'd15);
    assign w_wr_idx  = r_cnt[5:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ovf       = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_byte   = 8'h00;
        case (r_state)
            LOAD: begin
                w_wr_en   = in_valid;
                w_wr_byte = in_byte;
                if (in_valid) begin
                    if (in_last && pad_en) begin
                        if (w_cnt_inc == BLOCK_BYTES) begin
                            w_state_nxt = SERVE;
                            w_ovf       = 1'b1;
                        end else begin
                            w_state_nxt = PAD;
                        end
                    end else if (in_last || (w_cnt_inc == BLOCK_BYTES)) begin
                        w_state_nxt = SERVE;
                    end
                end
            end
            PAD: begin
                w_wr_en = 1'b1;
                if (r_pad_first) begin
                    w_wr_byte = PAD_BYTE;
                end else if (r_fit && (r_cnt >= LEN_BYTE_OFS)) begin
                    w_wr_byte = r_len[{~r_cnt[1:0], 3'b000} +: 8];
                end
                if (r_cnt == BLOCK_BYTES - 7'd1) begin
                    w_state_nxt = SERVE;
                    w_ovf       = !r_fit;
                end
            end
            SERVE: begin
                if (w_release) begin
                    w_state_nxt = LOAD;
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx[5:2]][{~w_wr_idx[1:0], 3'b000} +: 8] <= w_wr_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 7'd0;
            r_pad_first <= 1'b0;
            r_fit       <= 1'b0;
            r_len       <= 32'd0;
            r_wait      <= 4'd0;
            r_addr      <= 4'd0;
            r_rdy       <= 1'b0;
            r_data      <= 32'd0;
            r_pad_ovf   <= 1'b0;
        end else begin
            r_rdy     <= w_issue;
            r_pad_ovf <= w_ovf;
            if (w_issue) begin
                r_data <= r_mem[addr];
                r_addr <= addr;
            end
            if (r_rdy || !rq) begin
                r_wait <= 4'd0;
            end else if (r_wait != LP_WAIT) begin
                r_wait <= r_wait + 4'd1;
            end
            case (r_state)
                LOAD: begin
                    if (in_valid) begin
                        r_cnt <= w_cnt_inc;
                        if (in_last && pad_en) begin
                            r_pad_first <= 1'b1;
                            // 0x80 plus the 8-byte length must fit behind the data
                            r_fit       <= (w_cnt_inc <= 7'd55);
                            r_len       <= len_bits;
                        end
                    end
                end
                PAD: begin
                    r_cnt       <= w_cnt_inc;
                    r_pad_first <= 1'b0;
                end
                SERVE: begin
                    if (w_release) begin
                        r_cnt <= 7'd0;
                    end
                end
                default: r_cnt <= 7'd0;
            endcase
        end
    end

    assign in_ready = (r_state == LOAD);
    assign full     = (r_state == SERVE);
    assign rdy      = r_rdy;
    assign data     = r_data;
    assign pad_ovf  = r_pad_ovf;

endmodule

// File: tb/tb_sha256_msg_server.sv
// tb/tb_sha256_msg_server.sv - directed self-checking bench for sha256_msg_server
module tb_sha256_msg_server;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_last;
    logic        pad_en;
    logic [31:0] len_bits;
    logic [3:0]  addr;
    logic        rq0, rq3;
    logic        in_ready0, rdy0, full0, pad_ovf0;
    logic        in_ready3, rdy3, full3, pad_ovf3;
    logic [31:0] data0, data3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sha256_msg_server #(.RDY_WAIT(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last),
        .in_ready(in_ready0), .pad_en(pad_en), .len_bits(len_bits), .addr(addr), .rq(rq0),
        .rdy(rdy0), .data(data0), .full(full0), .pad_ovf(pad_ovf0)
    );

    sha256_msg_server #(.RDY_WAIT(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last),
        .in_ready(in_ready3), .pad_en(pad_en), .len_bits(len_bits), .addr(addr), .rq(rq3),
        .rdy(rdy3), .data(data3), .full(full3), .pad_ovf(pad_ovf3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_block(input logic [7:0] base, input int count, input logic last,
                              input logic pad);
        for (int i = 0; i < count; i++) begin
            in_valid = 1'b1;
            in_byte  = base + 8'(i);
            in_last  = last && (i == count - 1);
            pad_en   = pad;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        pad_en   = 1'b0;
    endtask

    task automatic read0(input logic [3:0] a, output logic [31:0] d, output int lat);
        addr = a;
        rq0  = 1'b1;
        lat  = -1;
        d    = 32'd0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (rdy0 === 1'b1) begin
                lat = k;
                d   = data0;
                break;
            end
        end
        rq0 = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] seq_word(input logic [7:0] base, input int w);
        logic [7:0] b;
        b = base + 8'(4 * w);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (rdy0 !== 1'b0 || full0 !== 1'b0 || pad_ovf0 !== 1'b0 || in_ready0 !== 1'b1 ||
            data0 !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b full=%b pad_ovf=%b in_ready=%b data=%h, want 0 0 0 1 00000000",
                     rdy0, full0, pad_ovf0, in_ready0, data0);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (rdy0 !== 1'b0 || full0 !== 1'b0 || in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: rdy=%b full=%b in_ready=%b, want 0 0 1", rdy0, full0, in_ready0);
        end
    endtask

    task automatic test_linear;
        logic [31:0] d;
        int lat;
        load_block(8'h00, 63, 1'b0, 1'b0);
        checks++;
        if (full0 !== 1'b0 || in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL lin_63_bytes: full=%b in_ready=%b, want 0 1", full0, in_ready0);
        end
        load_block(8'h3F, 1, 1'b0, 1'b0);
        checks++;
        if (full0 !== 1'b1 || in_ready0 !== 1'b0) begin
            errors++;
            $display("FAIL lin_64_bytes: full=%b in_ready=%b, want 1 0", full0, in_ready0);
        end
        for (int w = 0; w < 16; w++) begin
            read0(4'(w), d, lat);
            checks++;
            if (d !== seq_word(8'h00, w) || lat !== 1) begin
                errors++;
                $display("FAIL lin_word%0d: data=%h lat=%0d, want %h lat=1", w, d, lat, seq_word(8'h00, w));
            end
            if (w == 14) begin
                checks++;
                if (full0 !== 1'b1) begin
                    errors++;
                    $display("FAIL lin_hold_full: full=%b, want 1", full0);
                end
            end
        end
        checks++;
        if (full0 !== 1'b0 || in_ready0 !== 1'b1 || rdy0 !== 1'b0) begin
            errors++;
            $display("FAIL lin_release: full=%b in_ready=%b rdy=%b, want 0 1 0", full0, in_ready0, rdy0);
        end
    endtask

    task automatic test_rdy_wait;
        int lat;
        logic bad;
        addr = 4'd5;
        rq3  = 1'b1;
        lat  = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (rdy3 === 1'b1) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat !== 4 || data3 !== 32'h14151617) begin
            errors++;
            $display("FAIL wait_latency: lat=%0d data=%h, want 4 14151617", lat, data3);
        end
        bad = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (rdy3 !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL wait_no_double_ack: rdy seen high in 4 cycles after ack, want low");
        end
        tick();
        checks++;
        if (rdy3 !== 1'b1 || data3 !== 32'h14151617) begin
            errors++;
            $display("FAIL wait_reack: rdy=%b data=%h, want 1 14151617", rdy3, data3);
        end
        rq3 = 1'b0;
        tick();
        addr = 4'd15;
        rq3  = 1'b1;
        lat  = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (rdy3 === 1'b1) begin
                lat = k;
                break;
            end
        end
        rq3 = 1'b0;
        checks++;
        if (lat !== 4 || data3 !== 32'h3C3D3E3F) begin
            errors++;
            $display("FAIL wait_word15: lat=%0d data=%h, want 4 3c3d3e3f", lat, data3);
        end
        tick();
        checks++;
        if (full3 !== 1'b0 || in_ready3 !== 1'b1) begin
            errors++;
            $display("FAIL wait_release: full=%b in_ready=%b, want 0 1", full3, in_ready3);
        end
    endtask

    task automatic test_pad_abc;
        logic [31:0] d;
        logic [31:0] exp;
        int lat;
        int ovf;
        int cyc;
        len_bits = 32'd24;
        load_block(8'h61, 3, 1'b1, 1'b1);
        checks++;
        if (in_ready0 !== 1'b0 || full0 !== 1'b0) begin
            errors++;
            $display("FAIL abc_enter_pad: in_ready=%b full=%b, want 0 0", in_ready0, full0);
        end
        ovf = 0;
        cyc = 0;
        while (full0 !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
            if (pad_ovf0 === 1'b1) ovf++;
        end
        checks++;
        if (cyc !== 61 || ovf !== 0) begin
            errors++;
            $display("FAIL abc_pad_cycles: cycles=%0d ovf=%0d, want 61 0", cyc, ovf);
        end
        for (int w = 0; w < 16; w++) begin
            exp = (w == 0) ? 32'h61626380 : (w == 15) ? 32'h00000018 : 32'h0;
            read0(4'(w), d, lat);
            checks++;
            if (d !== exp || lat !== 1) begin
                errors++;
                $display("FAIL abc_word%0d: data=%h lat=%0d, want %h lat=1", w, d, lat, exp);
            end
        end
    endtask

    task automatic test_pad_ovf60;
        logic [31:0] d;
        int lat;
        int ovf;
        int cyc;
        len_bits = 32'h000001E0;
        load_block(8'h00, 60, 1'b1, 1'b1);
        ovf = 0;
        cyc = 0;
        while (full0 !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
            if (pad_ovf0 === 1'b1) ovf++;
        end
        tick();
        if (pad_ovf0 === 1'b1) ovf++;
        checks++;
        if (cyc !== 4 || ovf !== 1) begin
            errors++;
            $display("FAIL p60_pad: cycles=%0d ovf_pulses=%0d, want 4 1", cyc, ovf);
        end
        read0(4'd14, d, lat);
        checks++;
        if (d !== 32'h38393A3B) begin
            errors++;
            $display("FAIL p60_word14: data=%h, want 38393a3b", d);
        end
        read0(4'd15, d, lat);
        checks++;
        if (d !== 32'h80000000) begin
            errors++;
            $display("FAIL p60_word15: data=%h, want 80000000", d);
        end
        checks++;
        if (full0 !== 1'b0) begin
            errors++;
            $display("FAIL p60_release: full=%b, want 0", full0);
        end
    endtask

    task automatic test_pad_64;
        logic [31:0] d;
        int lat;
        len_bits = 32'd512;
        load_block(8'hA0, 64, 1'b1, 1'b1);
        checks++;
        if (full0 !== 1'b1 || pad_ovf0 !== 1'b1) begin
            errors++;
            $display("FAIL p64_direct: full=%b pad_ovf=%b, want 1 1", full0, pad_ovf0);
        end
        tick();
        checks++;
        if (pad_ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL p64_pulse: pad_ovf=%b, want 0", pad_ovf0);
        end
        read0(4'd0, d, lat);
        checks++;
        if (d !== 32'hA0A1A2A3) begin
            errors++;
            $display("FAIL p64_word0: data=%h, want a0a1a2a3", d);
        end
        read0(4'd15, d, lat);
        checks++;
        if (d !== 32'hDCDDDEDF) begin
            errors++;
            $display("FAIL p64_word15: data=%h, want dcdddedf", d);
        end
    endtask

    task automatic test_stall;
        logic [31:0] d;
        int lat;
        logic bad;
        load_block(8'h80, 10, 1'b0, 1'b0);
        addr = 4'd2;
        rq0  = 1'b1;
        bad  = 1'b0;
        for (int i = 10; i < 64; i++) begin
            in_valid = 1'b1;
            in_byte  = 8'h80 + 8'(i);
            tick();
            if (rdy0 !== 1'b0) bad = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (bad !== 1'b0 || full0 !== 1'b1) begin
            errors++;
            $display("FAIL stall_load: rdy_early=%b full=%b, want 0 1", bad, full0);
        end
        tick();
        checks++;
        if (rdy0 !== 1'b1 || data0 !== 32'h88898A8B) begin
            errors++;
            $display("FAIL stall_ack: rdy=%b data=%h, want 1 88898a8b", rdy0, data0);
        end
        rq0 = 1'b0;
        tick();
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        in_last  = 1'b1;
        pad_en   = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (in_ready0 !== 1'b0 || full0 !== 1'b1 || pad_ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL serve_ignore: in_ready=%b full=%b pad_ovf=%b, want 0 1 0", in_ready0, full0, pad_ovf0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        pad_en   = 1'b0;
        read0(4'd0, d, lat);
        checks++;
        if (d !== 32'h80818283) begin
            errors++;
            $display("FAIL serve_word0: data=%h, want 80818283", d);
        end
        read0(4'd15, d, lat);
        checks++;
        if (d !== 32'hBCBDBEBF || full0 !== 1'b0) begin
            errors++;
            $display("FAIL serve_word15: data=%h full=%b, want bcbdbebf 0", d, full0);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        int lat;
        len_bits = 32'd40;
        load_block(8'h00, 5, 1'b1, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (rdy0 !== 1'b0 || full0 !== 1'b0 || in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL rst_pad: rdy=%b full=%b in_ready=%b, want 0 0 1", rdy0, full0, in_ready0);
        end
        tick();
        rst = 1'b0;
        tick();
        load_block(8'h10, 64, 1'b0, 1'b0);
        addr = 4'd7;
        rq0  = 1'b1;
        lat  = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (rdy0 === 1'b1) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat !== 1 || data0 !== 32'h2C2D2E2F) begin
            errors++;
            $display("FAIL rst_pre_word7: lat=%0d data=%h, want 1 2c2d2e2f", lat, data0);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rdy0 !== 1'b0 || full0 !== 1'b0 || in_ready0 !== 1'b1 || data0 !== 32'd0) begin
            errors++;
            $display("FAIL rst_serve: rdy=%b full=%b in_ready=%b data=%h, want 0 0 1 00000000",
                     rdy0, full0, in_ready0, data0);
        end
        rq0 = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        load_block(8'h40, 64, 1'b0, 1'b0);
        read0(4'd0, d, lat);
        checks++;
        if (d !== 32'h40414243 || lat !== 1) begin
            errors++;
            $display("FAIL rst_after_word0: data=%h lat=%0d, want 40414243 1", d, lat);
        end
        read0(4'd15, d, lat);
        checks++;
        if (d !== 32'h7C7D7E7F || full0 !== 1'b0 || in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL rst_after_word15: data=%h full=%b in_ready=%b, want 7c7d7e7f 0 1",
                     d, full0, in_ready0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        in_last  = 1'b0;
        pad_en   = 1'b0;
        len_bits = 32'd0;
        addr     = 4'd0;
        rq0      = 1'b0;
        rq3      = 1'b0;
        test_reset();
        test_linear();
        test_rdy_wait();
        test_pad_abc();
        test_pad_ovf60();
        test_pad_64();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
